ptr_frame_asm: RTL and testbench

Paper-tape reader front end: accepts 8-bit tape frames from a tape source stream and assembles them into 36-bit words for the processor's read-in and DATAI path. It sits directly upstream of the pdp6 processor's I/O side, supplying the words that read-in mode loads into memory. It emulates reader mechanics with a per-frame gap, supports binary (six 6-bit frames per word) and alphanumeric (one frame per word) modes, and exposes the busy/flag handshake the processor polls or clears.

---
 rtl/ptr_frame_asm_if.sv | 23 ++
 rtl/ptr_frame_asm.sv | 134 +++++++++++++
 tb/tb_ptr_frame_asm.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ptr_frame_asm_if.sv
// Bundle between the paper-tape reader front end, its tape source and the processor I/O side.
// The slave modport is the reader itself; the master modport is whoever drives frames and commands.
interface ptr_frame_asm_if;
  logic        frame_valid;
  logic [7:0]  frame_data;
  logic        frame_ready;
  logic        mode_bin;
  logic        start;
  logic        clr;
  logic        busy;
  logic        flag;
  logic [35:0] word;

  modport master (
    output frame_valid, frame_data, mode_bin, start, clr,
    input  frame_ready, busy, flag, word
  );

  modport slave (
    input  frame_valid, frame_data, mode_bin, start, clr,
    output frame_ready, busy, flag, word
  );
endinterface

// File: rtl/ptr_frame_asm.sv
// Paper-tape reader front end: assembles 8-bit tape frames into 36-bit words,
// either six 6-bit binary frames per word or one alphanumeric frame per word.
module ptr_frame_asm #(
  parameter int unsigned FRAME_DLY = 8
) (
  input logic             clk,
  input logic             reset,
  ptr_frame_asm_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [7:0] GAP_LOAD = 8'(FRAME_DLY - 1);

  state_e      state_q, state_d;
  logic [35:0] word_q,  word_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  gap_q,   gap_d;
  logic        mode_q,  mode_d;
  logic        busy_q,  busy_d;
  logic        flag_q,  flag_d;
  logic        ready_q, ready_d;

  logic accept;
  assign accept = bus.frame_valid & ready_q;

  always_comb begin
    // NOTE: every next-state variable takes its current value first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    gap_d   = gap_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    flag_d  = flag_q;
    ready_d = ready_q;

    if (bus.clr) begin
      // clr beats a coincident start; the assembled word is left as it was
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      flag_d  = 1'b0;
      count_d = '0;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d = ST_WAIT;
            word_d  = '0;
            count_d = '0;
            flag_d  = 1'b0;
            busy_d  = 1'b1;
            mode_d  = bus.mode_bin;
            ready_d = 1'b1;
          end
        end

        ST_WAIT: begin
          if (accept) begin
            if (!mode_q) begin
              word_d  = {28'b0, bus.frame_data};
              state_d = ST_DONE;
              flag_d  = 1'b1;
              busy_d  = 1'b0;
              ready_d = 1'b0;
            end else begin
              // blank (leader) frames have no hole 8 and are skipped, but still cost a tape advance
              if (bus.frame_data[7]) begin
                word_d  = {word_q[29:0], bus.frame_data[5:0]};
                count_d = count_q + 3'd1;
              end
              if (bus.frame_data[7] && (count_q == 3'd5)) begin
                state_d = ST_DONE;
                flag_d  = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b0;
              end else begin
                state_d = ST_GAP;
                gap_d   = GAP_LOAD;
                ready_d = 1'b0;
              end
            end
          end
        end

        ST_GAP: begin
          if (gap_q == 8'd0) begin
            state_d = ST_WAIT;
            ready_d = 1'b1;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses nonblocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      count_q <= '0;
      gap_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      flag_q  <= flag_d;
      ready_q <= ready_d;
    end
  end

  assign bus.frame_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.flag        = flag_q;
  assign bus.word        = word_q;

endmodule

// File: tb/tb_ptr_frame_asm.sv
// Bench for ptr_frame_asm: a queued tape source feeds the FRAME_DLY=8 reader, a scoreboard
// holds expected words until the flag rises; a second reader with FRAME_DLY=1 checks the short gap.
module tb_ptr_frame_asm;

  localparam int D8 = 8;
  localparam int D1 = 1;

  logic clk;
  logic reset;

  ptr_frame_asm_if bus8();
  ptr_frame_asm_if bus1();

  ptr_frame_asm #(.FRAME_DLY(D8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  ptr_frame_asm #(.FRAME_DLY(D1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [7:0]  src_q[$];
  logic [35:0] sb_q[$];
  int          n_checks;
  int          n_errors;
  logic        src_acc;
  int          low8;
  int          low1;
  logic        flag8_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Tape source for dut8: presents the head of src_q and drops it once the reader takes it.
  initial begin
    bus8.frame_valid = 1'b0;
    bus8.frame_data  = 8'h00;
    forever begin
      @(posedge clk);
      src_acc = bus8.frame_valid & bus8.frame_ready;
      #1;
      if (src_acc && src_q.size() != 0) void'(src_q.pop_front());
      bus8.frame_valid = (src_q.size() != 0);
      bus8.frame_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    end
  end

  // Monitors: gap length while busy, and scoreboard compare on each rising flag.
  initial begin
    low8 = 0;
    low1 = 0;
    flag8_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus8.busy) low8 = 0;
      else if (!bus8.frame_ready) low8++;
      else if (low8 != 0) begin
        check("gap8_len", 64'(low8), 64'(D8));
        low8 = 0;
      end
      if (!bus1.busy) low1 = 0;
      else if (!bus1.frame_ready) low1++;
      else if (low1 != 0) begin
        check("gap1_len", 64'(low1), 64'(D1));
        low1 = 0;
      end
      if (bus8.flag && !flag8_prev) begin
        if (sb_q.size() == 0) check("unexpected_flag", 64'(1), 64'(0));
        else begin
          check("word", 64'(bus8.word), 64'(sb_q.pop_front()));
          check("busy_at_flag", 64'(bus8.busy), 64'(0));
        end
      end
      flag8_prev = bus8.flag;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic m);
    @(negedge clk);
    bus8.start    = 1'b1;
    bus8.mode_bin = m;
    @(negedge clk);
    bus8.start    = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus8.clr = 1'b1;
    @(negedge clk);
    bus8.clr = 1'b0;
  endtask

  // Counts negedges since the start edge (the first one already passed inside pulse_start).
  task automatic wait_flag(input int budget, output int n);
    n = 1;
    while (!bus8.flag && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("flag_seen", 64'(bus8.flag), 64'(1));
  endtask

  task automatic wait_src(input int target, input int budget);
    int k;
    k = 0;
    while (src_q.size() != target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("src_level", 64'(src_q.size()), 64'(target));
  endtask

  task automatic push_frames_81_86();
    for (int i = 1; i <= 6; i++) src_q.push_back(8'(8'h80 + i));
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    bus8.start    = 1'b0;
    bus8.clr      = 1'b0;
    bus8.mode_bin = 1'b0;
    bus1.start    = 1'b0;
    bus1.clr      = 1'b0;
    bus1.mode_bin = 1'b0;
    bus1.frame_valid = 1'b0;
    bus1.frame_data  = 8'h00;
    n_checks = 0;
    n_errors = 0;

    #12;
    check("rst_busy",  64'(bus8.busy),        64'(0));
    check("rst_flag",  64'(bus8.flag),        64'(0));
    check("rst_word",  64'(bus8.word),        64'(0));
    check("rst_ready", 64'(bus8.frame_ready), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // binary word, minimum word time from start
    push_frames_81_86();
    sb_q.push_back(36'o010203040506);
    pulse_start(1'b1);
    wait_flag(200, n);
    check("bin_latency", 64'(n), 64'(1 + 5 * (D8 + 1) + 1));
    @(negedge clk);
    check("done_ready", 64'(bus8.frame_ready), 64'(0));

    // leader skip: three blanks each take a gap before the data frames
    repeat (3) src_q.push_back(8'h00);
    repeat (6) src_q.push_back(8'hBF);
    sb_q.push_back(36'o777777777777);
    pulse_start(1'b1);
    wait_flag(300, n);
    check("leader_latency", 64'(n), 64'(1 + 8 * (D8 + 1) + 1));

    // alpha: one frame completes the word on its accept edge, the next is refused
    src_q.push_back(8'h41);
    src_q.push_back(8'h42);
    sb_q.push_back(36'o000000000101);
    pulse_start(1'b0);
    wait_flag(50, n);
    check("alpha_latency", 64'(n), 64'(2));
    repeat (20) @(negedge clk);
    check("alpha_refuse", 64'(src_q.size()), 64'(1));
    check("alpha_hold_word", 64'(bus8.word), 64'(36'o000000000101));
    check("alpha_hold_flag", 64'(bus8.flag), 64'(1));
    src_q.delete();
    repeat (2) @(negedge clk);

    // clr after three binary frames, then a full word proves the count restarted
    src_q.push_back(8'h81);
    src_q.push_back(8'h82);
    src_q.push_back(8'h83);
    pulse_start(1'b1);
    wait_src(0, 200);
    pulse_clr();
    check("clr_busy",  64'(bus8.busy),        64'(0));
    check("clr_flag",  64'(bus8.flag),        64'(0));
    check("clr_ready", 64'(bus8.frame_ready), 64'(0));
    check("clr_word",  64'(bus8.word),        64'(36'o000000010203));
    push_frames_81_86();
    sb_q.push_back(36'o010203040506);
    pulse_start(1'b1);
    wait_flag(200, n);
    check("restart_latency", 64'(n), 64'(1 + 5 * (D8 + 1) + 1));

    // simultaneous clr and start from DONE: clr wins, block stays idle
    @(negedge clk);
    bus8.clr   = 1'b1;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.clr   = 1'b0;
    bus8.start = 1'b0;
    check("clrstart_busy",  64'(bus8.busy),        64'(0));
    check("clrstart_flag",  64'(bus8.flag),        64'(0));
    check("clrstart_ready", 64'(bus8.frame_ready), 64'(0));
    repeat (5) @(negedge clk);
    check("clrstart_idle", 64'(bus8.busy), 64'(0));

    // start while busy (with a mode change) must not disturb word, count or mode
    src_q.push_back(8'h81);
    src_q.push_back(8'h82);
    sb_q.push_back(36'o010203040506);
    pulse_start(1'b1);
    wait_src(0, 200);
    pulse_start(1'b0);
    for (int i = 3; i <= 6; i++) src_q.push_back(8'(8'h80 + i));
    wait_flag(300, n);

    // asynchronous reset between edges while in GAP
    push_frames_81_86();
    pulse_start(1'b1);
    wait_src(5, 50);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy",  64'(bus8.busy),        64'(0));
    check("arst_flag",  64'(bus8.flag),        64'(0));
    check("arst_ready", 64'(bus8.frame_ready), 64'(0));
    check("arst_word",  64'(bus8.word),        64'(0));
    #1;
    reset = 1'b0;
    src_q.delete();
    repeat (12) @(negedge clk);
    check("arst_idle_busy",  64'(bus8.busy),        64'(0));
    check("arst_idle_ready", 64'(bus8.frame_ready), 64'(0));

    // FRAME_DLY=1 reader with a source that is always valid
    bus1.mode_bin    = 1'b1;
    bus1.frame_data  = 8'h81;
    bus1.frame_valid = 1'b1;
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    n = 1;
    while (!bus1.flag && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("d1_latency", 64'(n),         64'(1 + 5 * (D1 + 1) + 1));
    check("d1_word",    64'(bus1.word), 64'(36'o010101010101));
    check("d1_busy",    64'(bus1.busy), 64'(0));
    bus1.frame_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
